branch_resolve_unit: RTL and testbench

Parametrised, pipelined successor to the single-cycle branch-condition judge. Takes a branch micro-op from execute (operands, funct3, PC, immediate, front-end prediction), evaluates the condition and target over a 2-stage elastic valid/ready pipeline, and reports the actual outcome, misprediction, redirect PC and faults. Also keeps saturating branch and mispredict performance counters. Sits between the issue/execute stage and the front-end redirect and commit logic.

---
 rtl/branch_pkg.sv | 41 ++++
 rtl/branch_resolve_unit_cmp.sv | 24 ++
 rtl/branch_resolve_unit.sv | 207 ++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolve unit:
//   - RISC-V branch funct3 encodings
//   - sequential PC increment
//   - per-stage flag payload structs (wide fields travel as separate registers
//     so the structs stay independent of XLEN)
//   - legality helper for funct3
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned PC_INC = 32'd4;

    // Flags captured when an op is accepted into stage 1
    typedef struct packed {
        logic taken;
        logic illegal;
        logic pred_taken;
    } s1_flags_t;

    // Flags presented on the output from stage 2
    typedef struct packed {
        logic taken;
        logic illegal;
        logic mispredict;
        logic misalign;
    } s2_flags_t;

    // 010 and 011 are the only unassigned branch encodings
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return !((f3 == 3'b010) || (f3 == 3'b011));
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// -----------------------------------------------------------------------------
// branch_cmp
// Combinational XLEN-wide comparator used by stage 1.
// Ports:
//   i_a, i_b        operands
//   o_eq            i_a == i_b
//   o_lt_signed     i_a <  i_b (two's complement)
//   o_lt_unsigned   i_a <  i_b (unsigned)
// -----------------------------------------------------------------------------
module branch_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_eq,
    output logic            o_lt_signed,
    output logic            o_lt_unsigned
);

    assign o_eq          = (i_a == i_b);
    assign o_lt_signed   = ($signed(i_a) < $signed(i_b));
    assign o_lt_unsigned = (i_a < i_b);

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Two-stage elastic branch resolver. Stage 1 evaluates the condition and
// target of an accepted branch; stage 2 decides misprediction/misalignment
// and drives the result. Saturating retired-branch and mispredict counters.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        input handshake
//   in_rs1, in_rs2, in_funct3  condition operands and encoding
//   in_pc, in_imm              branch PC and sign-extended offset
//   in_pred_taken/_target      front-end prediction
//   out_valid / out_ready      output handshake
//   out_taken, out_target, out_redirect_pc, out_mispredict,
//   out_illegal, out_misalign  resolved result
//   flush                      drop everything in flight, block input
//   cnt_clear                  synchronous counter clear
//   branch_cnt, mispred_cnt    performance counters
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic             out_misalign,
    input  logic             flush,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Stage 1 state
    logic              r_s1_valid;
    s1_flags_t         r_s1_flags;
    logic [XLEN-1:0]   r_s1_target;
    logic [XLEN-1:0]   r_s1_pc4;
    logic [XLEN-1:0]   r_s1_pred_target;

    // Stage 2 state
    logic              r_s2_valid;
    s2_flags_t         r_s2_flags;
    logic [XLEN-1:0]   r_s2_target;
    logic [XLEN-1:0]   r_s2_redirect;

    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_mispred_cnt;

    logic              w_eq;
    logic              w_lt_s;
    logic              w_lt_u;
    logic              w_taken;
    logic              w_illegal;
    logic              w_s2_load;
    logic              w_s1_load;
    logic              w_accept;
    logic              w_out_hs;
    logic              w_misalign;
    logic              w_mispredict;
    logic [XLEN-1:0]   w_redirect;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .i_a           (in_rs1),
        .i_b           (in_rs2),
        .o_eq          (w_eq),
        .o_lt_signed   (w_lt_s),
        .o_lt_unsigned (w_lt_u)
    );

    // A stage may load when it is empty or its content moves on this cycle.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = rst_n && !flush && w_s1_load;
    assign w_accept  = in_valid && in_ready;
    assign w_out_hs  = r_s2_valid && out_ready && !flush;
    assign w_illegal = !f3_is_legal(in_funct3);

    // Branch condition decode; unassigned encodings resolve not-taken
    always_comb begin
        w_taken = 1'b0;
        case (in_funct3)
            F3_BEQ:  w_taken = w_eq;
            F3_BNE:  w_taken = !w_eq;
            F3_BLT:  w_taken = w_lt_s;
            F3_BGE:  w_taken = !w_lt_s;
            F3_BLTU: w_taken = w_lt_u;
            F3_BGEU: w_taken = !w_lt_u;
            default: w_taken = 1'b0;
        endcase
    end

    // Stage 2 decisions from stage 1 contents; misalignment forces a redirect
    always_comb begin
        w_misalign   = 1'b0;
        w_mispredict = 1'b0;
        w_redirect   = r_s1_pc4;
        if (IALIGN == 16) begin
            w_misalign = r_s1_flags.taken && r_s1_target[0];
        end else begin
            w_misalign = r_s1_flags.taken && (r_s1_target[1:0] != 2'b00);
        end
        w_mispredict = (!r_s1_flags.illegal &&
                        ((r_s1_flags.taken != r_s1_flags.pred_taken) ||
                         (r_s1_flags.taken && (r_s1_target != r_s1_pred_target))))
                       || w_misalign;
        if (r_s1_flags.taken) begin
            w_redirect = r_s1_target;
        end else begin
            w_redirect = r_s1_pc4;
        end
    end

    // Stage 1 register: valid bit plus payload captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid       <= 1'b0;
            r_s1_flags       <= '0;
            r_s1_target      <= '0;
            r_s1_pc4         <= '0;
            r_s1_pred_target <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_flags.taken      <= w_taken;
                r_s1_flags.illegal    <= w_illegal;
                r_s1_flags.pred_taken <= in_pred_taken;
                r_s1_target           <= in_pc + in_imm;
                r_s1_pc4              <= in_pc + XLEN'(PC_INC);
                r_s1_pred_target      <= in_pred_target;
            end
        end
    end

    // Stage 2 register: holds the presented result while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_s2_flags    <= '0;
            r_s2_target   <= '0;
            r_s2_redirect <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_flags.taken      <= r_s1_flags.taken;
                r_s2_flags.illegal    <= r_s1_flags.illegal;
                r_s2_flags.mispredict <= w_mispredict;
                r_s2_flags.misalign   <= w_misalign;
                r_s2_target           <= r_s1_target;
                r_s2_redirect         <= w_redirect;
            end
        end
    end

    // Saturating performance counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (cnt_clear) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_out_hs && !r_s2_flags.illegal) begin
            if (r_branch_cnt != CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (r_s2_flags.mispredict && (r_mispred_cnt != CNT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
            end
        end
    end

    assign out_valid       = r_s2_valid;
    assign out_taken       = r_s2_flags.taken;
    assign out_target      = r_s2_target;
    assign out_redirect_pc = r_s2_redirect;
    assign out_mispredict  = r_s2_flags.mispredict;
    assign out_illegal     = r_s2_flags.illegal;
    assign out_misalign    = r_s2_flags.misalign;
    assign branch_cnt      = r_branch_cnt;
    assign mispred_cnt     = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed vectors with hand-computed expectations. Each accepted op pushes
// its expected result into a scoreboard queue; an independent monitor compares
// the queue head against the DUT whenever a result is presented.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
    import branch_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pt;
        logic [31:0] ptgt;
    } op_t;

    typedef struct {
        logic        tk;
        logic [31:0] tgt, rd;
        logic        mis, ill, mal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0, in_pred_target = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_pred_taken = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_taken, out_mispredict, out_illegal, out_misalign;
    logic [31:0] out_target, out_redirect_pc;
    logic        flush = 1'b0;
    logic        cnt_clear = 1'b0;
    logic [3:0]  branch_cnt, mispred_cnt;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   out_idx = 0;
    exp_t sb[$];
    int   pop_cyc[$];

    branch_resolve_unit #(.XLEN(32), .IALIGN(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target),
        .out_redirect_pc(out_redirect_pc), .out_mispredict(out_mispredict),
        .out_illegal(out_illegal), .out_misalign(out_misalign),
        .flush(flush), .cnt_clear(cnt_clear),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic op_t mk_op(input logic [2:0] f3, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic pt,
                                  input logic [31:0] ptgt);
        op_t o;
        o.f3 = f3; o.rs1 = rs1; o.rs2 = rs2; o.pc = pc; o.imm = imm;
        o.pt = pt; o.ptgt = ptgt;
        return o;
    endfunction

    function automatic exp_t mk_exp(input logic tk, input logic [31:0] tgt,
                                    input logic [31:0] rd, input logic mis,
                                    input logic ill, input logic mal);
        exp_t e;
        e.tk = tk; e.tgt = tgt; e.rd = rd; e.mis = mis; e.ill = ill; e.mal = mal;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic drive(input op_t o);
        in_valid = 1'b1;
        in_funct3 = o.f3; in_rs1 = o.rs1; in_rs2 = o.rs2;
        in_pc = o.pc; in_imm = o.imm;
        in_pred_taken = o.pt; in_pred_target = o.ptgt;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Present an op until accepted; returns 1 time unit after the capturing edge.
    task automatic send(input op_t o, input exp_t e);
        bit done;
        done = 1'b0;
        drive(o);
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept: op pc=%0h not accepted within 50 cycles", o.pc);
        end
    endtask

    // Wait for all expected results to retire, then past the counting edge.
    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d results still pending", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string nm, input logic [3:0] b, input logic [3:0] m);
        chk({nm, "_branch_cnt"}, {28'd0, branch_cnt}, {28'd0, b});
        chk({nm, "_mispred_cnt"}, {28'd0, mispred_cnt}, {28'd0, m});
    endtask

    // Monitor: every presented result is compared with the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && !flush) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out[%0d]: unexpected result tgt=%0h, none expected", out_idx, out_target);
            end else if (out_taken !== sb[0].tk || out_target !== sb[0].tgt ||
                         out_redirect_pc !== sb[0].rd || out_mispredict !== sb[0].mis ||
                         out_illegal !== sb[0].ill || out_misalign !== sb[0].mal) begin
                errors++;
                $display("FAIL out[%0d]: got tk=%b tgt=%0h rd=%0h mis=%b ill=%b mal=%b expected tk=%b tgt=%0h rd=%0h mis=%b ill=%b mal=%b",
                         out_idx, out_taken, out_target, out_redirect_pc, out_mispredict,
                         out_illegal, out_misalign, sb[0].tk, sb[0].tgt, sb[0].rd,
                         sb[0].mis, sb[0].ill, sb[0].mal);
            end
            if (out_ready && sb.size() != 0) begin
                void'(sb.pop_front());
                pop_cyc.push_back(cyc);
                out_idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_out_redirect", out_redirect_pc, 32'd0);
        chk_cnt("rst", 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // BEQ taken, correctly predicted; result on the second edge after capture
        send(mk_op(F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120),
             mk_exp(1'b1, 32'h120, 32'h120, 1'b0, 1'b0, 1'b0));
        idle();
        @(negedge clk);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        drain();
        chk_cnt("beq", 4'd1, 4'd0);

        // Signed versus unsigned compare of the same operands
        send(mk_op(F3_BLT, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 1'b1, 32'h210),
             mk_exp(1'b1, 32'h210, 32'h210, 1'b0, 1'b0, 1'b0));
        send(mk_op(F3_BLTU, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 1'b1, 32'h210),
             mk_exp(1'b0, 32'h210, 32'h204, 1'b1, 1'b0, 1'b0));
        idle();
        drain();
        chk_cnt("blt", 4'd3, 4'd1);

        // Back-to-back burst of 8 with out_ready held high
        pop_cyc.delete();
        send(mk_op(F3_BNE,  32'd3, 32'd4, 32'h1000, 32'h8, 1'b1, 32'h1008),
             mk_exp(1'b1, 32'h1008, 32'h1008, 1'b0, 1'b0, 1'b0));
        send(mk_op(F3_BGE,  32'h80000000, 32'd0, 32'h1004, 32'hFFFFFFF0, 1'b0, 32'h0),
             mk_exp(1'b0, 32'h0FF4, 32'h1008, 1'b0, 1'b0, 1'b0));
        send(mk_op(F3_BGEU, 32'h80000000, 32'd0, 32'h1008, 32'hFFFFFFF0, 1'b0, 32'h0),
             mk_exp(1'b1, 32'h0FF8, 32'h0FF8, 1'b1, 1'b0, 1'b0));
        send(mk_op(F3_BEQ,  32'd7, 32'd8, 32'h100C, 32'h40, 1'b1, 32'h104C),
             mk_exp(1'b0, 32'h104C, 32'h1010, 1'b1, 1'b0, 1'b0));
        send(mk_op(F3_BLT,  32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1010, 32'h100, 1'b1, 32'h1110),
             mk_exp(1'b1, 32'h1110, 32'h1110, 1'b0, 1'b0, 1'b0));
        send(mk_op(F3_BLTU, 32'd2, 32'd3, 32'h1014, 32'h20, 1'b1, 32'h1030),
             mk_exp(1'b1, 32'h1034, 32'h1034, 1'b1, 1'b0, 1'b0));
        send(mk_op(F3_BNE,  32'd9, 32'd9, 32'h1018, 32'h4, 1'b0, 32'h0),
             mk_exp(1'b0, 32'h101C, 32'h101C, 1'b0, 1'b0, 1'b0));
        send(mk_op(F3_BGEU, 32'd5, 32'd5, 32'hFFFFFFFC, 32'h8, 1'b1, 32'h4),
             mk_exp(1'b1, 32'h4, 32'h4, 1'b0, 1'b0, 1'b0));
        idle();
        drain();
        chk("burst_count", pop_cyc.size(), 32'd8);
        if (pop_cyc.size() == 8) chk("burst_span", pop_cyc[7] - pop_cyc[0], 32'd7);
        chk_cnt("burst", 4'd11, 4'd4);

        // Consumer stall: both stages fill, input blocked, head result held
        out_ready = 1'b0;
        send(mk_op(F3_BEQ, 32'd1, 32'd1, 32'h2000, 32'h10, 1'b1, 32'h2010),
             mk_exp(1'b1, 32'h2010, 32'h2010, 1'b0, 1'b0, 1'b0));
        send(mk_op(F3_BNE, 32'd1, 32'd1, 32'h2004, 32'h10, 1'b0, 32'h0),
             mk_exp(1'b0, 32'h2014, 32'h2008, 1'b0, 1'b0, 1'b0));
        drive(mk_op(F3_BLTU, 32'd0, 32'd1, 32'h2008, 32'h20, 1'b0, 32'h0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(mk_op(F3_BLTU, 32'd0, 32'd1, 32'h2008, 32'h20, 1'b0, 32'h0),
             mk_exp(1'b1, 32'h2028, 32'h2028, 1'b1, 1'b0, 1'b0));
        idle();
        drain();
        chk_cnt("stall", 4'd14, 4'd5);

        // Illegal encodings do not count; misaligned taken target forces redirect
        send(mk_op(3'b010, 32'd1, 32'd1, 32'h3000, 32'h40, 1'b1, 32'h3040),
             mk_exp(1'b0, 32'h3040, 32'h3004, 1'b0, 1'b1, 1'b0));
        send(mk_op(3'b011, 32'd1, 32'd2, 32'h3200, 32'h0, 1'b0, 32'h0),
             mk_exp(1'b0, 32'h3200, 32'h3204, 1'b0, 1'b1, 1'b0));
        idle();
        drain();
        chk_cnt("illegal", 4'd14, 4'd5);
        send(mk_op(F3_BNE, 32'd1, 32'd2, 32'h3100, 32'h2, 1'b1, 32'h3102),
             mk_exp(1'b1, 32'h3102, 32'h3102, 1'b1, 1'b0, 1'b1));
        idle();
        drain();
        chk_cnt("misalign", 4'd15, 4'd6);

        // Counter clear without a handshake
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        chk_cnt("clear", 4'd0, 4'd0);

        // Flush with both stages full, input pending and consumer ready
        out_ready = 1'b0;
        send(mk_op(F3_BEQ, 32'd2, 32'd2, 32'h6000, 32'h10, 1'b0, 32'h0),
             mk_exp(1'b1, 32'h6010, 32'h6010, 1'b1, 1'b0, 1'b0));
        send(mk_op(F3_BEQ, 32'd2, 32'd3, 32'h6004, 32'h10, 1'b1, 32'h6014),
             mk_exp(1'b0, 32'h6014, 32'h6008, 1'b1, 1'b0, 1'b0));
        drive(mk_op(F3_BNE, 32'd2, 32'd3, 32'h6008, 32'h10, 1'b1, 32'h6018));
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk_cnt("flush", 4'd0, 4'd0);
        @(negedge clk);
        chk("flush_no_accept", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Saturation: 16 mispredicting branches on 4-bit counters
        for (int i = 0; i < 16; i++) begin
            send(mk_op(F3_BEQ, 32'd1, 32'd2, 32'h4000 + 32'(i * 4), 32'h10, 1'b1, 32'h0),
                 mk_exp(1'b0, 32'h4010 + 32'(i * 4), 32'h4004 + 32'(i * 4), 1'b1, 1'b0, 1'b0));
        end
        idle();
        drain();
        chk_cnt("sat", 4'd15, 4'd15);

        // Clear coincident with an output handshake
        send(mk_op(F3_BEQ, 32'd1, 32'd2, 32'h4100, 32'h10, 1'b1, 32'h0),
             mk_exp(1'b0, 32'h4110, 32'h4104, 1'b1, 1'b0, 1'b0));
        idle();
        @(posedge clk); #1;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        chk_cnt("clear_hs", 4'd0, 4'd0);
        chk("clear_hs_drained", sb.size(), 32'd0);

        // Asynchronous reset mid-stream
        send(mk_op(F3_BEQ, 32'd4, 32'd4, 32'h7000, 32'h8, 1'b1, 32'h7008),
             mk_exp(1'b1, 32'h7008, 32'h7008, 1'b0, 1'b0, 1'b0));
        send(mk_op(F3_BNE, 32'd4, 32'd4, 32'h7004, 32'h8, 1'b0, 32'h0),
             mk_exp(1'b0, 32'h700C, 32'h7008, 1'b0, 1'b0, 1'b0));
        idle();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Recovery after reset
        send(mk_op(F3_BGE, 32'd5, 32'd5, 32'h5000, 32'h8, 1'b1, 32'h5008),
             mk_exp(1'b1, 32'h5008, 32'h5008, 1'b0, 1'b0, 1'b0));
        idle();
        drain();
        chk_cnt("recover", 4'd1, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
